// File: rtl/mem_req_seq.sv
`default_nettype none
// =============================================================================
// mem_req_seq : ez8 data-memory request sequencer (READ/WRITE/INC/BITOP,
//               optional pointer-indirect addressing with post-increment)
// Revision    : 1.0
// =============================================================================
module mem_req_seq #(
    parameter logic [7:0] INDIRECT_BASE = 8'h04
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_addr,
    input  logic       req_indirect,
    input  logic       req_postinc,
    input  logic [7:0] req_wdata,
    input  logic [2:0] req_bit,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       resp_z,
    output logic [7:0] readaddr,
    input  logic [7:0] readdata,
    output logic [7:0] writeaddr,
    output logic [7:0] writedata,
    output logic       write_en
);

    localparam logic [1:0] c_OP_READ  = 2'b00;
    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_INC   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PTR    = 3'd1,
        S_PTRCAP = 3'd2,
        S_ISSUE  = 3'd3,
        S_CAP    = 3'd4,
        S_WB     = 3'd5,
        S_RESP   = 3'd6
    } state_t;

    state_t     r_state;
    logic [1:0] r_op;
    logic [1:0] r_sel;
    logic       r_postinc;
    logic [7:0] r_wdata;
    logic [2:0] r_bit;
    logic [7:0] r_ea;
    logic [7:0] r_result;
    logic       r_resp_valid;
    logic [7:0] r_resp_data;
    logic       r_resp_z;

    logic [7:0] w_ptr_addr;
    logic [7:0] w_rd_inc;
    logic [7:0] w_bit_result;

    assign w_ptr_addr = INDIRECT_BASE + {6'd0, r_sel};
    assign w_rd_inc   = readdata + 8'd1;

    always_comb begin
        w_bit_result        = readdata;
        w_bit_result[r_bit] = r_wdata[0];
    end

    assign req_ready  = (r_state == S_IDLE) && !reset;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_z     = r_resp_z;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= 2'd0;
            r_sel        <= 2'd0;
            r_postinc    <= 1'b0;
            r_wdata      <= 8'd0;
            r_bit        <= 3'd0;
            r_ea         <= 8'd0;
            r_result     <= 8'd0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 8'd0;
            r_resp_z     <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op      <= req_op;
                        r_sel     <= req_addr[1:0];
                        r_postinc <= req_postinc;
                        r_wdata   <= req_wdata;
                        r_bit     <= req_bit;
                        r_ea      <= req_addr;
                        r_state   <= req_indirect ? S_PTR : S_ISSUE;
                    end
                end
                S_PTR:    r_state <= S_PTRCAP;
                S_PTRCAP: begin
                    r_ea    <= readdata;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (r_op == c_OP_WRITE) begin
                        r_resp_data  <= r_wdata;
                        r_resp_z     <= (r_wdata == 8'd0);
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_state <= S_CAP;
                    end
                end
                S_CAP: begin
                    if (r_op == c_OP_READ) begin
                        r_resp_data  <= readdata;
                        r_resp_z     <= (readdata == 8'd0);
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_result <= (r_op == c_OP_INC) ? w_rd_inc : w_bit_result;
                        r_state  <= S_WB;
                    end
                end
                S_WB: begin
                    r_resp_data  <= r_result;
                    r_resp_z     <= (r_result == 8'd0);
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP:   r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Bus drive follows the current state; PTRCAP forwards readdata+1 in the same cycle.
    always_comb begin
        readaddr  = 8'd0;
        writeaddr = 8'd0;
        writedata = 8'd0;
        write_en  = 1'b0;
        case (r_state)
            S_PTR: readaddr = w_ptr_addr;
            S_PTRCAP: begin
                if (r_postinc) begin
                    write_en  = 1'b1;
                    writeaddr = w_ptr_addr;
                    writedata = w_rd_inc;
                end
            end
            S_ISSUE: begin
                if (r_op == c_OP_WRITE) begin
                    write_en  = 1'b1;
                    writeaddr = r_ea;
                    writedata = r_wdata;
                end else begin
                    readaddr = r_ea;
                end
            end
            S_WB: begin
                write_en  = 1'b1;
                writeaddr = r_ea;
                writedata = r_result;
            end
            default: ;
        endcase
        if (reset) write_en = 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_seq.sv
`default_nettype none
// tb_mem_req_seq : directed + randomized checks of mem_req_seq against a
//                  register-file model and an abstract operation model.
module tb_mem_req_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'd0;
    logic [7:0] req_addr = 8'd0;
    logic       req_indirect = 1'b0;
    logic       req_postinc = 1'b0;
    logic [7:0] req_wdata = 8'd0;
    logic [2:0] req_bit = 3'd0;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       resp_z;
    logic [7:0] readaddr;
    logic [7:0] readdata = 8'd0;
    logic [7:0] writeaddr;
    logic [7:0] writedata;
    logic       write_en;

    mem_req_seq #(.INDIRECT_BASE(8'h04)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_indirect(req_indirect), .req_postinc(req_postinc),
        .req_wdata(req_wdata), .req_bit(req_bit),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_z(resp_z),
        .readaddr(readaddr), .readdata(readdata),
        .writeaddr(writeaddr), .writedata(writedata), .write_en(write_en)
    );

    always #5 clk = ~clk;

    // Register file: one-cycle read latency, plus a backdoor write port for preloading
    logic [7:0] rf   [0:255];
    logic [7:0] mmem [0:255];
    logic       bd_we = 1'b0;
    logic [7:0] bd_addr = 8'd0;
    logic [7:0] bd_data = 8'd0;

    always @(posedge clk) begin
        if (write_en) rf[writeaddr] <= writedata;
        if (bd_we)    rf[bd_addr]   <= bd_data;
        readdata <= rf[readaddr];
    end

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] ob_ra [0:15];
    logic [7:0] ob_wa [0:15];
    logic [7:0] ob_wd [0:15];
    logic       ob_we [0:15];
    logic [7:0] last_data;
    logic       last_z;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        mmem[a] = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // Issue one request and check it against the abstract model.
    task automatic run_req(input logic [1:0] op, input logic [7:0] addr, input logic ind,
                           input logic pinc, input logic [7:0] wd, input logic [2:0] bt);
        logic [7:0] ptr, ea, res;
        int exp_lat, exp_wr, n_wr, lat_seen, n_rv;
        ptr = 8'h04 + {6'd0, addr[1:0]};
        ea  = ind ? mmem[ptr] : addr;
        exp_wr = 0;
        if (ind && pinc) begin
            mmem[ptr] = mmem[ptr] + 8'd1;
            exp_wr++;
        end
        case (op)
            2'b00: res = mmem[ea];
            2'b01: res = wd;
            2'b10: res = mmem[ea] + 8'd1;
            default: begin res = mmem[ea]; res[bt] = wd[0]; end
        endcase
        if (op != 2'b00) begin
            mmem[ea] = res;
            exp_wr++;
        end
        exp_lat = (op == 2'b01) ? 2 : (op == 2'b00) ? 3 : 4;
        if (ind) exp_lat += 2;

        @(negedge clk);
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_indirect = ind;
        req_postinc = pinc; req_wdata = wd; req_bit = bt;
        @(posedge clk);
        n_wr = 0; lat_seen = 0; n_rv = 0;
        for (int k = 1; k <= exp_lat + 1; k++) begin
            if (k > 1) @(posedge clk);
            #1;
            ob_ra[k] = readaddr; ob_we[k] = write_en; ob_wa[k] = writeaddr; ob_wd[k] = writedata;
            if (write_en) n_wr++;
            if (resp_valid) begin
                n_rv++;
                if (lat_seen == 0) lat_seen = k;
                last_data = resp_data;
                last_z    = resp_z;
            end
            if (k == 1) begin
                check("ready_busy", req_ready, 0);
                // junk on the request port while busy must be ignored
                req_op = 2'($urandom); req_addr = 8'($urandom); req_indirect = 1'($urandom);
                req_postinc = 1'($urandom); req_wdata = 8'($urandom); req_bit = 3'($urandom);
            end
            if (k == exp_lat) begin
                check("ready_resp", req_ready, 0);
                req_valid = 1'b0;
            end
        end
        check("latency", lat_seen, exp_lat);
        check("resp_count", n_rv, 1);
        check("resp_data", last_data, res);
        check("resp_z", last_z, (res == 8'd0));
        check("write_count", n_wr, exp_wr);
        check("mem_ea", rf[ea], mmem[ea]);
        check("mem_ptr", rf[ptr], mmem[ptr]);
    endtask

    initial begin
        int bad;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_z", resp_z, 0);
        check("rst_write_en", write_en, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom));

        // direct READ
        poke(8'h20, 8'h5A);
        run_req(2'b00, 8'h20, 1'b0, 1'b0, 8'h00, 3'd0);
        check("rd_readaddr_T1", ob_ra[1], 8'h20);
        check("rd_data", last_data, 8'h5A);

        // direct WRITE
        run_req(2'b01, 8'h31, 1'b0, 1'b0, 8'hC3, 3'd0);
        check("wr_we_T1", ob_we[1], 1);
        check("wr_addr_T1", ob_wa[1], 8'h31);
        check("wr_data_T1", ob_wd[1], 8'hC3);

        // INC wrap
        poke(8'h40, 8'hFF);
        run_req(2'b10, 8'h40, 1'b0, 1'b0, 8'h00, 3'd0);
        check("inc_we_T3", ob_we[3], 1);
        check("inc_addr_T3", ob_wa[3], 8'h40);
        check("inc_data_T3", ob_wd[3], 8'h00);
        check("inc_z", last_z, 1);

        // indirect READ with post-increment
        poke(8'h05, 8'h22);
        poke(8'h22, 8'h77);
        run_req(2'b00, 8'h01, 1'b1, 1'b1, 8'h00, 3'd0);
        check("ind_we_T2", ob_we[2], 1);
        check("ind_wa_T2", ob_wa[2], 8'h05);
        check("ind_wd_T2", ob_wd[2], 8'h23);
        check("ind_ra_T3", ob_ra[3], 8'h22);
        check("ind_data", last_data, 8'h77);
        run_req(2'b00, 8'h05, 1'b0, 1'b0, 8'h00, 3'd0);
        check("ptr_followup", last_data, 8'h23);

        // pointer wrap with BITOP
        poke(8'h07, 8'hFF);
        poke(8'hFF, 8'h00);
        run_req(2'b11, 8'h03, 1'b1, 1'b1, 8'h01, 3'd6);
        check("bit_ptr", rf[8'h07], 8'h00);
        check("bit_mem", rf[8'hFF], 8'h40);
        check("bit_data", last_data, 8'h40);
        check("bit_z", last_z, 0);

        // reset during CAP of an INC
        poke(8'h50, 8'h10);
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b10; req_addr = 8'h50; req_indirect = 1'b0; req_postinc = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        check("rstmid_we_cap", write_en, 0);
        check("rstmid_ready_cap", req_ready, 0);
        @(posedge clk);
        #1;
        check("rstmid_we_hold", write_en, 0);
        check("rstmid_rv_hold", resp_valid, 0);
        check("rstmid_ready_hold", req_ready, 0);
        check("rstmid_resp_data", resp_data, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_ready_after", req_ready, 1);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (write_en || resp_valid) bad++;
            @(posedge clk);
            #1;
        end
        check("rstmid_quiet", bad, 0);
        check("rstmid_mem", rf[8'h50], 8'h10);

        // randomized requests
        for (int i = 0; i < 60; i++) begin
            run_req(2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                    8'($urandom), 3'($urandom));
        end

        bad = 0;
        for (int a = 0; a < 256; a++) if (rf[a] !== mmem[a]) bad++;
        check("mem_final", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mem_req_seq.md
Name: mem_req_seq

Overview:
- Initiator-side sequencer for the data-memory port of the ez8 core; drives readaddr/writeaddr/writedata/write_en and consumes readdata.
- Turns single-cycle requests (READ, WRITE, INC, BITOP) into correctly timed register-file accesses, honouring the one-cycle read latency.
- Supports indirect addressing through pointer registers 0x04-0x07, with optional post-increment of the pointer.
- Sits between the decode/execute logic and the register-file controller.

Parameters:
- INDIRECT_BASE, 8'h04, address of indirect pointer register 0; pointer n is at INDIRECT_BASE+n.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_op  input  2  00 READ, 01 WRITE, 10 INC, 11 BITOP
- req_addr  input  8  direct address; when req_indirect=1, bits [1:0] select the pointer
- req_indirect  input  1  use the pointer's contents as the effective address (EA)
- req_postinc  input  1  with req_indirect=1, write pointer+1 back to the pointer
- req_wdata  input  8  write data (WRITE); bit 0 is the set/clear value (BITOP)
- req_bit  input  3  bit index for BITOP
- resp_valid  output  1  one-cycle response pulse
- resp_data  output  8  read value (READ), written value (WRITE), or new value (INC/BITOP)
- resp_z  output  1  resp_data == 0
- readaddr  output  8  to the register file; data is valid the cycle after it is driven
- readdata  input  8  from the register file
- writeaddr  output  8  to the register file
- writedata  output  8  to the register file
- write_en  output  1  to the register file

Behaviour:
- States: IDLE, PTR, PTRCAP, ISSUE, CAP, WB, RESP.
- IDLE:
  - req_ready=1.
  - Request accepted on req_valid && req_ready; all request fields are latched.
  - Next state is PTR if req_indirect, else ISSUE (EA = req_addr).
- PTR: readaddr = INDIRECT_BASE + req_addr[1:0].
- PTRCAP:
  - EA <= readdata.
  - If postinc: write_en=1, writeaddr = pointer address, writedata = readdata+1 (8-bit wrap, FF->00).
  - Next state ISSUE.
- ISSUE:
  - READ/INC/BITOP: readaddr = EA; next state CAP.
  - WRITE: write_en=1, writeaddr=EA, writedata=req_wdata; next state RESP.
- CAP:
  - Capture readdata.
  - READ -> RESP.
  - INC -> WB with result = readdata+1 (wrap).
  - BITOP -> WB with result = readdata with bit req_bit forced to req_wdata[0].
- WB: write_en=1, writeaddr=EA, writedata=result; next state RESP.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - resp_data/resp_z hold the result and remain stable until the next RESP.
  - Next state IDLE; a new request can be accepted the following cycle.
- req_ready is 0 in every state except IDLE; no queuing.
- Default bus values outside the states above:
  - readaddr=0, writeaddr=0, writedata=0, write_en=0.
  - write_en is never asserted except in PTRCAP (postinc only), ISSUE (WRITE only) and WB.
- Latency from the accept cycle T to resp_valid:
  - Direct: READ T+3, WRITE T+2, INC/BITOP T+4.
  - Indirect: add 2 cycles.
- Hazards:
  - Post-increment write followed by a read of the same address in ISSUE depends on the register file's write-to-read forwarding; the sequencer adds no stall.
  - An EA equal to the pointer address is legal.
- Addresses 0x00-0x0F are not special-cased: writes to 0x00 are issued normally, and the status register (0x01) may be targeted.
- Reset:
  - state=IDLE, resp_valid=0, resp_data=0, resp_z=0, latched fields=0.
  - req_ready=0 while reset is high.
  - write_en is forced 0 in any cycle where reset=1.
  - Reset mid-operation aborts it with no further writes and no response.
- req_valid while busy is ignored; it is not latched.

Test Plan:
- Direct READ:
  - Preload 0x20=0x5A, request READ addr 0x20.
  - Require readaddr=0x20 at T+1, resp_valid at T+3, resp_data=0x5A, resp_z=0.
- Direct WRITE:
  - Request WRITE addr 0x31 data 0xC3.
  - Require write_en=1 at T+1 with writeaddr=0x31 and writedata=0xC3, resp_valid at T+2, req_ready low during T+1..T+2.
- INC wrap:
  - Preload 0x40=0xFF, request INC addr 0x40.
  - Require a WB write of 0x00 to 0x40 at T+3, resp_valid at T+4, resp_data=0x00, resp_z=1.
- Indirect READ with postinc:
  - Set 0x05=0x22 and 0x22=0x77, request READ indirect sel=1 postinc.
  - Require a write of 0x23 to 0x05 at T+2, readaddr=0x22 at T+3, resp_data=0x77 at T+5.
  - A follow-up read of 0x05 returns 0x23.
- Pointer wrap and BITOP:
  - Set 0x07=0xFF and 0xFF=0x00, request BITOP indirect sel=3 postinc, bit 6, set value 1.
  - Require pointer 0x07 written to 0x00, 0xFF written to 0x40, resp_data=0x40, resp_z=0.
- Reset mid-op:
  - Assert reset during CAP of an INC.
  - Require no write_en in or after the reset cycle, no resp_valid, and req_ready=1 the cycle after reset is released.
